image_stream_filter: RTL and testbench
======================================

Name: image_stream_filter

Overview:
- Streaming 3x3 neighbourhood filter for RGB888 raster images: one pixel in and one pixel out per handshake.
- Converts each pixel to grayscale, then applies a run-time selected operation: grayscale, Gaussian blur, Sobel magnitude or threshold.
- Holds only two line buffers; it never stores a whole frame.
- Sits between the image source (file reader or camera front end) and the image writer. Supplies the writer's line sync and frame-done.

Parameters:
- WIDTH, 300, pixels per line (>=3).
- HEIGHT, 400, lines per frame (>=3).
- PAD_VAL, 0, 8-bit grayscale value used for every out-of-image neighbour.
- THRESHOLD, 90, comparison level for threshold mode.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- mode  in  2  operation: 0 gray, 1 gaussian, 2 sobel, 3 threshold.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts a pixel.
- in_r, in_g, in_b  in  8 each  input pixel, raster order.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- DATA_R, DATA_G, DATA_B  out  8 each  result; all three carry the same value.
- HSYNC  out  1  high with out_valid on the last pixel of each line.
- out_last  out  1  high with out_valid on the final pixel of the frame.
- ctrl_done  out  1  one-cycle pulse, cycle after final output handshake.

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: all outputs 0, in_ready 0, state IDLE, counters 0, line buffers don't-care.
- Reset mid-frame: partial frame discarded; the next accepted pixel is pixel (0,0).
- Handshakes: a transfer occurs when valid&&ready. out_valid, data, HSYNC and out_last hold stable until out_ready.
- Grayscale: g = (R+G+B)/3, truncated, using a 10-bit sum.
- FSM states:
  - IDLE: in_ready=1. First accepted pixel latches mode for the whole frame (later mode changes ignored) -> FILL.
  - FILL: accept pixels until WIDTH+1 pixels have been accepted -> RUN. No output in FILL.
  - RUN: each accepted input pixel k (0-based) causes output pixel k-WIDTH-1. After the final input pixel (index WIDTH*HEIGHT-1) is accepted -> FLUSH.
  - FLUSH: in_ready=0. Emits the remaining WIDTH+1 outputs back-to-back, subject to out_ready, with neighbours beyond the last row or column taken as PAD_VAL. After the final output handshake -> DONE.
  - DONE: ctrl_done=1 for one cycle -> IDLE.
- in_ready is 0 whenever out_valid && !out_ready (single output register, no skid). in_ready is 1 in IDLE/FILL/RUN otherwise.
- Latency: the output register loads on the cycle after the triggering input handshake. With no stall, throughput is 1 pixel/cycle.
- Window: 3x3 grayscale neighbourhood centred on the output pixel. Any neighbour outside the image (row -1, row HEIGHT, column -1, column WIDTH) reads PAD_VAL. A line boundary never wraps to the adjacent line.
- Modes:
  - 0: centre g.
  - 1: kernel [1 2 1; 2 4 2; 1 2 1]; result = (sum+8)>>4, at least 12-bit sum.
  - 2: gx, gy standard Sobel as signed 12-bit values; result = min(255, |gx|+|gy|).
  - 3: centre g >= THRESHOLD ? 255 : 0.
- Counters: row/column/pixel counters sized by $clog2. HSYNC is asserted on output column WIDTH-1. Exactly WIDTH*HEIGHT outputs per frame.
- In IDLE with in_valid low: no state change and no outputs.

Test Plan:
- WIDTH=4, HEIGHT=3, mode 0, every pixel (10,20,31) -> 12 outputs of 20. HSYNC on outputs 3, 7, 11; out_last on 11; ctrl_done the cycle after.
- Same frame, mode 3, pixels (90,90,90), THRESHOLD 90 -> all 255. Pixels (89,89,89) -> all 0.
- WIDTH=HEIGHT=3, PAD_VAL=0, mode 1, centre 160, rest 0 -> corners 10, edges 20, centre 40.
- WIDTH=4, HEIGHT=3, PAD_VAL=0, mode 2, columns 0-1 = 0, columns 2-3 = 200 -> output (1,1)=255. Constant 100 image with PAD_VAL=100 -> all 0.
- Backpressure: out_ready toggled 1-0-0-1 randomly, in_valid random -> identical output sequence to the no-stall run. Data stable while stalled; in_ready 0 while stalled.
- Assert HRESETn low mid-frame after 5 pixels, then send a full frame -> outputs 0 during reset; the new frame is fully correct with no residue; mode change mid-frame is ignored.

Source files
------------

// File: rtl/image_stream_filter.sv
// image_stream_filter: RGB888 -> gray, 3x3 neighbourhood stream filter.
// Two line buffers; modes gray, gaussian, sobel magnitude, threshold.
module image_stream_filter #(
  parameter int         WIDTH     = 300,
  parameter int         HEIGHT    = 400,
  parameter logic [7:0] PAD_VAL   = 8'd0,
  parameter logic [7:0] THRESHOLD = 8'd90
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B,
  output logic       HSYNC,
  output logic       out_last,
  output logic       ctrl_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH * HEIGHT + 1);

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(HEIGHT - 1);
  localparam logic [PW-1:0] P_FILL = PW'(WIDTH);
  localparam logic [PW-1:0] P_LAST = PW'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t          state;
  logic            live;
  logic [1:0]      mode_q;
  logic [CW-1:0]   ci;
  logic [CW-1:0]   co;
  logic [RW-1:0]   ro;
  logic [PW-1:0]   pcnt;
  logic            fl_done;
  logic [7:0]      dat;

  logic [7:0]      lb0 [WIDTH];
  logic [7:0]      lb1 [WIDTH];
  logic [2:0][7:0] w0;
  logic [2:0][7:0] w1;
  logic [2:0][7:0] col;

  logic            slot;
  logic            acc;
  logic            fstep;
  logic            emit;
  logic            step;

  logic [9:0]      sum3;
  logic [7:0]      gray_in;

  logic            pt, pb, pl, pr;
  logic [11:0]     z00, z01, z02;
  logic [11:0]     z10, z11, z12;
  logic [11:0]     z20, z21, z22;
  logic [11:0]     gs;
  logic [11:0]     gx, gy, ax, ay, mag;
  logic [7:0]      res;

  assign DATA_R = dat;
  assign DATA_G = dat;
  assign DATA_B = dat;

  // single output register: anything new waits until it drains
  assign slot     = !(out_valid && !out_ready);
  assign in_ready = live && slot &&
                    (state == IDLE || state == FILL || state == RUN);
  assign acc      = in_valid && in_ready;
  assign fstep    = (state == FLUSH) && slot && !fl_done;
  assign emit     = ((state == RUN) && acc) || fstep;
  assign step     = acc || fstep;

  assign sum3    = 10'(in_r) + 10'(in_g) + 10'(in_b);
  assign gray_in = 8'(sum3 / 10'd3);

  // newest column: rows two above, one above, current
  assign col = {gray_in, lb1[ci], lb0[ci]};

  assign pt = (ro == '0);
  assign pb = (ro == R_LAST);
  assign pl = (co == '0);
  assign pr = (co == C_LAST);

  function automatic logic [11:0] px(input logic [7:0] v,
                                     input logic       pad);
    return {4'b0, pad ? PAD_VAL : v};
  endfunction

  // left = older window column, centre = newer, right = incoming
  assign z00 = px(w1[0], pt | pl);
  assign z01 = px(w0[0], pt);
  assign z02 = px(col[0], pt | pr);
  assign z10 = px(w1[1], pl);
  assign z11 = px(w0[1], 1'b0);
  assign z12 = px(col[1], pr);
  assign z20 = px(w1[2], pb | pl);
  assign z21 = px(w0[2], pb);
  assign z22 = px(col[2], pb | pr);

  assign gs = z00 + (z01 << 1) + z02 +
              (z10 << 1) + (z11 << 2) + (z12 << 1) +
              z20 + (z21 << 1) + z22 + 12'd8;

  assign gx = (z02 + (z12 << 1) + z22) -
              (z00 + (z10 << 1) + z20);
  assign gy = (z20 + (z21 << 1) + z22) -
              (z00 + (z01 << 1) + z02);
  assign ax  = gx[11] ? (~gx + 12'd1) : gx;
  assign ay  = gy[11] ? (~gy + 12'd1) : gy;
  assign mag = ax + ay;

  always_comb begin
    res = w0[1];
    unique case (mode_q)
      2'd0: res = w0[1];
      2'd1: res = 8'(gs >> 4);
      2'd2: res = (mag > 12'd255) ? 8'hFF : 8'(mag);
      2'd3: res = (w0[1] >= THRESHOLD) ? 8'hFF : 8'h00;
      default: res = w0[1];
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (step) begin
      lb0[ci] <= lb1[ci];
      lb1[ci] <= gray_in;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      live      <= 1'b0;
      mode_q    <= '0;
      ci        <= '0;
      co        <= '0;
      ro        <= '0;
      pcnt      <= '0;
      fl_done   <= 1'b0;
      w0        <= '0;
      w1        <= '0;
      out_valid <= 1'b0;
      dat       <= '0;
      HSYNC     <= 1'b0;
      out_last  <= 1'b0;
      ctrl_done <= 1'b0;
    end else begin
      live <= 1'b1;

      if (emit) begin
        out_valid <= 1'b1;
        dat       <= res;
        HSYNC     <= pr;
        out_last  <= pr && pb;
        co        <= pr ? '0 : co + 1'b1;
        if (pr) begin
          ro <= pb ? '0 : ro + 1'b1;
        end
        if (pr && pb) begin
          fl_done <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        HSYNC     <= 1'b0;
        out_last  <= 1'b0;
      end

      if (step) begin
        w1 <= w0;
        w0 <= col;
        ci <= (ci == C_LAST) ? '0 : ci + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (acc) begin
            mode_q <= mode;
            pcnt   <= PW'(1);
            state  <= FILL;
          end
        end
        FILL: begin
          if (acc) begin
            pcnt <= pcnt + 1'b1;
            if (pcnt == P_FILL) state <= RUN;
          end
        end
        RUN: begin
          if (acc) begin
            pcnt <= pcnt + 1'b1;
            if (pcnt == P_LAST) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_valid && out_ready && out_last) begin
            state     <= DONE;
            ctrl_done <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          ctrl_done <= 1'b0;
          ci        <= '0;
          pcnt      <= '0;
          fl_done   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_filter.sv
// tb_image_stream_filter: directed frames on three parameterisations.
// Small 4x3 / 3x3 images with hand-computed expected outputs.
module tb_image_stream_filter;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic       HRESETn;
  logic [1:0] mode;
  logic       in_valid;
  logic [7:0] in_r, in_g, in_b;
  logic       out_ready;
  logic [1:0] sel;

  logic [2:0] iv, ir, ov, hs, ol, cd;
  logic [7:0] dr [3];
  logic [7:0] dg [3];
  logic [7:0] db [3];

  assign iv[0] = in_valid && (sel == 2'd0);
  assign iv[1] = in_valid && (sel == 2'd1);
  assign iv[2] = in_valid && (sel == 2'd2);

  image_stream_filter #(.WIDTH(4), .HEIGHT(3), .PAD_VAL(8'd0)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .mode(mode),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(ov[0]), .out_ready(out_ready),
    .DATA_R(dr[0]), .DATA_G(dg[0]), .DATA_B(db[0]),
    .HSYNC(hs[0]), .out_last(ol[0]), .ctrl_done(cd[0])
  );

  image_stream_filter #(.WIDTH(3), .HEIGHT(3), .PAD_VAL(8'd0)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .mode(mode),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(ov[1]), .out_ready(out_ready),
    .DATA_R(dr[1]), .DATA_G(dg[1]), .DATA_B(db[1]),
    .HSYNC(hs[1]), .out_last(ol[1]), .ctrl_done(cd[1])
  );

  image_stream_filter #(.WIDTH(4), .HEIGHT(3), .PAD_VAL(8'd100)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .mode(mode),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(ov[2]), .out_ready(out_ready),
    .DATA_R(dr[2]), .DATA_G(dg[2]), .DATA_B(db[2]),
    .HSYNC(hs[2]), .out_last(ol[2]), .ctrl_done(cd[2])
  );

  logic       o_ir, o_ov, o_hs, o_ol, o_cd;
  logic [7:0] o_r, o_g, o_b;

  always_comb begin
    o_ir = ir[0]; o_ov = ov[0]; o_hs = hs[0];
    o_ol = ol[0]; o_cd = cd[0];
    o_r = dr[0]; o_g = dg[0]; o_b = db[0];
    case (sel)
      2'd1: begin
        o_ir = ir[1]; o_ov = ov[1]; o_hs = hs[1];
        o_ol = ol[1]; o_cd = cd[1];
        o_r = dr[1]; o_g = dg[1]; o_b = db[1];
      end
      2'd2: begin
        o_ir = ir[2]; o_ov = ov[2]; o_hs = hs[2];
        o_ol = ol[2]; o_cd = cd[2];
        o_r = dr[2]; o_g = dg[2]; o_b = db[2];
      end
      default: ;
    endcase
  end

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] pr [12];
  logic [7:0] pg [12];
  logic [7:0] pb [12];
  logic [7:0] ex [12];
  logic [7:0] gr [12];
  logic [7:0] gg [12];
  logic [7:0] gb [12];
  logic       ghs [12];
  logic       glast [12];

  int n_out, stall_bad, rdy_bad, n_stall;
  bit done_ok, done_early, tmo;

  task automatic set_px(input int i, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b);
    pr[i] = r; pg[i] = g; pb[i] = b;
  endtask

  // drives one frame, records every output handshake
  task automatic run_frame(input logic [1:0] s, input logic [1:0] md,
                           input logic [1:0] md2, input bit bp,
                           input int n);
    int ip, cyc;
    bit fin, last_seen, stl;
    logic [7:0] sd;
    logic sh, sl;
    ip = 0; cyc = 0; fin = 0; last_seen = 0; stl = 0;
    sd = '0; sh = 0; sl = 0;
    n_out = 0; stall_bad = 0; rdy_bad = 0; n_stall = 0;
    done_ok = 0; done_early = 0; tmo = 0;
    for (int i = 0; i < 12; i++) begin
      gr[i] = 'x; gg[i] = 'x; gb[i] = 'x; ghs[i] = 'x; glast[i] = 'x;
    end
    sel = s;
    mode = md;
    while (!fin) begin
      @(negedge HCLK);
      cyc++;
      if (ip >= 1) mode = md2;
      if (last_seen) begin
        done_ok = o_cd;
        fin = 1;
      end else if (cyc > 3000) begin
        tmo = 1;
        fin = 1;
      end else begin
        out_ready = bp ? !((cyc % 4) == 1 || (cyc % 4) == 2) : 1'b1;
        if (ip < n) begin
          in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          in_r = pr[ip]; in_g = pg[ip]; in_b = pb[ip];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (o_cd) done_early = 1;
        if (stl && !(o_ov && o_r === sd && o_hs === sh && o_ol === sl))
          stall_bad++;
        if (o_ov && !out_ready) begin
          n_stall++;
          if (o_ir) rdy_bad++;
        end
        if (in_valid && o_ir) ip++;
        if (o_ov && out_ready) begin
          if (n_out < 12) begin
            gr[n_out] = o_r; gg[n_out] = o_g; gb[n_out] = o_b;
            ghs[n_out] = o_hs; glast[n_out] = o_ol;
          end
          n_out++;
          if (o_ol) last_seen = 1;
        end
        stl = o_ov && !out_ready;
        sd = o_r; sh = o_hs; sl = o_ol;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic test_reset;
    HRESETn = 1'b1;
    #2 HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    #1;
    vectors++;
    if ({ir, ov, hs, ol, cd} !== 15'd0 ||
        {dr[0], dg[0], db[0], dr[1], dr[2]} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b hs=%b last=%b done=%b data=%h required all 0",
               ir, ov, hs, ol, cd, dr[0]);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic test_idle;
    bit seen;
    seen = 0;
    sel = 2'd0;
    in_valid = 1'b0;
    repeat (6) begin
      @(negedge HCLK);
      #1;
      if (o_ov || o_cd || !o_ir) seen = 1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL idle: activity with in_valid low (vld=%b done=%b rdy=%b) required quiet and ready",
               o_ov, o_cd, o_ir);
    end
  endtask

  task automatic test_gray;
    for (int i = 0; i < 12; i++) begin
      set_px(i, 8'd10, 8'd20, 8'd31);
      ex[i] = 8'd20;
    end
    run_frame(2'd0, 2'd0, 2'd0, 1'b0, 12);
    vectors++;
    if (tmo || n_out != 12 || !done_ok || done_early) begin
      miscompares++;
      $display("FAIL gray frame: outputs %0d tmo %0b done %0b early %0b required 12/0/1/0",
               n_out, tmo, done_ok, done_early);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({gr[i], gg[i], gb[i], ghs[i], glast[i]} !==
          {ex[i], ex[i], ex[i], (i % 4) == 3, i == 11}) begin
        miscompares++;
        $display("FAIL gray px%0d: got %h/%h/%h hs%b last%b required %h hs%b last%b",
                 i, gr[i], gg[i], gb[i], ghs[i], glast[i],
                 ex[i], (i % 4) == 3, i == 11);
      end
    end
  endtask

  task automatic test_threshold;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 12; i++) begin
        if (t == 0) set_px(i, 8'd90, 8'd90, 8'd90);
        else set_px(i, 8'd89, 8'd89, 8'd89);
        ex[i] = (t == 0) ? 8'd255 : 8'd0;
      end
      run_frame(2'd0, 2'd3, 2'd3, 1'b0, 12);
      vectors++;
      if (tmo || n_out != 12 || !done_ok) begin
        miscompares++;
        $display("FAIL thresh%0d frame: outputs %0d done %0b required 12/1",
                 t, n_out, done_ok);
      end
      for (int i = 0; i < 12; i++) begin
        vectors++;
        if ({gr[i], ghs[i], glast[i]} !==
            {ex[i], (i % 4) == 3, i == 11}) begin
          miscompares++;
          $display("FAIL thresh%0d px%0d: got %h required %h",
                   t, i, gr[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_gaussian(input bit bp);
    logic [7:0] k [9];
    k = '{8'd10, 8'd20, 8'd10, 8'd20, 8'd40, 8'd20, 8'd10, 8'd20, 8'd10};
    for (int i = 0; i < 9; i++) begin
      if (i == 4) set_px(i, 8'd160, 8'd160, 8'd160);
      else set_px(i, 8'd0, 8'd0, 8'd0);
      ex[i] = k[i];
    end
    run_frame(2'd1, 2'd1, 2'd1, bp, 9);
    vectors++;
    if (tmo || n_out != 9 || !done_ok || done_early) begin
      miscompares++;
      $display("FAIL gauss frame bp%0b: outputs %0d done %0b required 9/1",
               bp, n_out, done_ok);
    end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if ({gr[i], gg[i], gb[i], ghs[i], glast[i]} !==
          {ex[i], ex[i], ex[i], (i % 3) == 2, i == 8}) begin
        miscompares++;
        $display("FAIL gauss px%0d bp%0b: got %h hs%b last%b required %h",
                 i, bp, gr[i], ghs[i], glast[i], ex[i]);
      end
    end
  endtask

  task automatic test_sobel;
    for (int i = 0; i < 12; i++) begin
      if ((i % 4) < 2) set_px(i, 8'd0, 8'd0, 8'd0);
      else set_px(i, 8'd200, 8'd200, 8'd200);
      ex[i] = ((i % 4) == 0) ? 8'd0 : 8'd255;
    end
    run_frame(2'd0, 2'd2, 2'd2, 1'b0, 12);
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({gr[i], ghs[i], glast[i]} !==
          {ex[i], (i % 4) == 3, i == 11}) begin
        miscompares++;
        $display("FAIL sobel edge px%0d: got %h required %h",
                 i, gr[i], ex[i]);
      end
    end
    for (int i = 0; i < 12; i++) set_px(i, 8'd100, 8'd100, 8'd100);
    run_frame(2'd2, 2'd2, 2'd2, 1'b0, 12);
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (gr[i] !== 8'd0) begin
        miscompares++;
        $display("FAIL sobel flat px%0d: got %h required 00", i, gr[i]);
      end
    end
    run_frame(2'd2, 2'd1, 2'd1, 1'b0, 12);
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (gr[i] !== 8'd100) begin
        miscompares++;
        $display("FAIL gauss flat pad px%0d: got %0d required 100", i, gr[i]);
      end
    end
  endtask

  task automatic load_ramp;
    for (int i = 0; i < 12; i++) begin
      set_px(i, 8'(10 * i), 8'(10 * i), 8'(10 * i));
      ex[i] = 8'(10 * i);
    end
  endtask

  task automatic test_back_to_back;
    load_ramp();
    run_frame(2'd0, 2'd0, 2'd0, 1'b1, 12);
    vectors++;
    if (tmo || n_out != 12 || !done_ok || n_stall == 0) begin
      miscompares++;
      $display("FAIL bp frame: outputs %0d done %0b stalls %0d required 12/1/>0",
               n_out, done_ok, n_stall);
    end
    vectors++;
    if (stall_bad != 0 || rdy_bad != 0) begin
      miscompares++;
      $display("FAIL bp stall: unstable %0d ready-while-stalled %0d required 0/0",
               stall_bad, rdy_bad);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({gr[i], ghs[i], glast[i]} !==
          {ex[i], (i % 4) == 3, i == 11}) begin
        miscompares++;
        $display("FAIL bp ramp px%0d: got %0d required %0d",
                 i, gr[i], ex[i]);
      end
    end
    test_gaussian(1'b1);
    vectors++;
    if (stall_bad != 0 || rdy_bad != 0) begin
      miscompares++;
      $display("FAIL bp gauss stall: unstable %0d ready-while-stalled %0d required 0/0",
               stall_bad, rdy_bad);
    end
  endtask

  task automatic test_reset_mid;
    int cnt, cyc;
    cnt = 0; cyc = 0;
    sel = 2'd0;
    mode = 2'd2;
    out_ready = 1'b1;
    while (cnt < 5 && cyc < 50) begin
      @(negedge HCLK);
      cyc++;
      in_valid = 1'b1;
      in_r = 8'd250; in_g = 8'd250; in_b = 8'd250;
      #1;
      if (o_ir) cnt++;
    end
    @(negedge HCLK);
    in_valid = 1'b0;
    HRESETn = 1'b0;
    #1;
    vectors++;
    if (cnt != 5 || {o_ir, o_ov, o_hs, o_ol, o_cd, o_r} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid reset: fed %0d rdy %b vld %b data %h required 5 fed, all 0",
               cnt, o_ir, o_ov, o_r);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    load_ramp();
    run_frame(2'd0, 2'd0, 2'd3, 1'b0, 12);
    vectors++;
    if (tmo || n_out != 12 || !done_ok) begin
      miscompares++;
      $display("FAIL post-reset frame: outputs %0d done %0b required 12/1",
               n_out, done_ok);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({gr[i], ghs[i], glast[i]} !==
          {ex[i], (i % 4) == 3, i == 11}) begin
        miscompares++;
        $display("FAIL post-reset px%0d: got %0d required %0d",
                 i, gr[i], ex[i]);
      end
    end
  endtask

  initial begin
    HRESETn = 1'b1;
    mode = 2'd0;
    in_valid = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    out_ready = 1'b1;
    sel = 2'd0;
    test_reset();
    test_idle();
    test_gray();
    test_threshold();
    test_gaussian(1'b0);
    test_sobel();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
